// File: rtl/shift_reg_if.sv
// Command/data bundle for shift_reg: load and shift commands, load word, and the
// registered word.
interface shift_reg_if #(
    parameter int WIDTH = 16
) ();
    logic             ld;
    logic             shiftEn;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;

    modport master (
        output ld,
        output shiftEn,
        output in,
        input  out
    );

    modport slave (
        input  ld,
        input  shiftEn,
        input  in,
        output out
    );
endinterface

// File: rtl/shift_reg.sv
// Parallel-load register that moves its word one position per enabled clock.
// Define SHIFT_REG_ROTATE_EN to rotate the word; otherwise FILL enters the vacated end.
module shift_reg #(
    parameter int   WIDTH      = 16,
    parameter int   SHIFT_LEFT = 1,
    parameter logic FILL       = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    shift_reg_if.slave bus
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_q_next;
    logic             w_in_bit;

    // Bit that enters the vacated end of the word
    always_comb begin
        w_in_bit = 1'b0;
`ifdef SHIFT_REG_ROTATE_EN
        if (SHIFT_LEFT != 0) begin
            w_in_bit = r_q[WIDTH-1];
        end else begin
            w_in_bit = r_q[0];
        end
`else
        w_in_bit = FILL;
`endif
    end

    // Word moved one position in the configured direction
    always_comb begin
        w_shifted = r_q;
        if (SHIFT_LEFT != 0) begin
            w_shifted = {r_q[WIDTH-2:0], w_in_bit};
        end else begin
            w_shifted = {w_in_bit, r_q[WIDTH-1:1]};
        end
    end

    // Load takes priority over shift; otherwise hold
    always_comb begin
        w_q_next = r_q;
        if (bus.ld) begin
            w_q_next = bus.in;
        end else if (bus.shiftEn) begin
            w_q_next = w_shifted;
        end else begin
            w_q_next = r_q;
        end
    end

    // State register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= {WIDTH{1'b0}};
        end else begin
            r_q <= w_q_next;
        end
    end

    assign bus.out = r_q;

endmodule

// File: tb/tb_shift_reg.sv
// Directed bench: a left/FILL=0 instance and a right/FILL=1 instance sharing clock and reset.
module tb_shift_reg;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_failed;

    shift_reg_if #(.WIDTH(16)) bus_l ();
    shift_reg_if #(.WIDTH(16)) bus_r ();

    shift_reg #(.WIDTH(16), .SHIFT_LEFT(1), .FILL(1'b0)) u_dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l.slave)
    );

    shift_reg #(.WIDTH(16), .SHIFT_LEFT(0), .FILL(1'b1)) u_dut_r (
        .clk (clk),
        .rst (rst),
        .bus (bus_r.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_failed = n_failed + 1;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_tests  = 0;
        n_failed = 0;
        rst           = 1'b1;
        bus_l.ld      = 1'b1;
        bus_l.shiftEn = 1'b0;
        bus_l.in      = 16'hFFFF;
        bus_r.ld      = 1'b0;
        bus_r.shiftEn = 1'b0;
        bus_r.in      = 16'h0000;

        // Reset beats a simultaneous load
        step(2);
        check_eq("reset_l", bus_l.out, 16'h0000);
        check_eq("reset_r", bus_r.out, 16'h0000);
        rst      = 1'b0;
        bus_l.ld = 1'b0;
        step(1);
        check_eq("reset_hold", bus_l.out, 16'h0000);

        // Load, then ignore in while ld low
        bus_l.ld = 1'b1;
        bus_l.in = 16'h4B6E;
        step(1);
        check_eq("load", bus_l.out, 16'h4B6E);
        bus_l.ld = 1'b0;
        bus_l.in = 16'h1234;
        step(1);
        check_eq("load_ignore_in", bus_l.out, 16'h4B6E);

        // Shift run
        bus_l.shiftEn = 1'b1;
        step(1);
        check_eq("shift1", bus_l.out, 16'h96DC);
        step(1);
`ifdef SHIFT_REG_ROTATE_EN
        check_eq("shift2", bus_l.out, 16'h2DB9);
        step(14);
        check_eq("shift16", bus_l.out, 16'h4B6E);
`else
        check_eq("shift2", bus_l.out, 16'h2DB8);
        step(14);
        check_eq("shift16", bus_l.out, 16'h0000);
        step(3);
        check_eq("shift_past_width", bus_l.out, 16'h0000);
`endif

        // Load beats shift, shifting resumes next edge
        bus_l.ld = 1'b1;
        bus_l.in = 16'h194D;
        step(1);
        check_eq("load_priority", bus_l.out, 16'h194D);
        bus_l.ld = 1'b0;
        step(1);
        check_eq("shift_after_load", bus_l.out, 16'h329A);

        // End bit behaviour with MSB set
        bus_l.shiftEn = 1'b0;
        bus_l.ld      = 1'b1;
        bus_l.in      = 16'h8001;
        step(1);
        bus_l.ld      = 1'b0;
        bus_l.shiftEn = 1'b1;
        step(1);
`ifdef SHIFT_REG_ROTATE_EN
        check_eq("msb_out", bus_l.out, 16'h0003);
`else
        check_eq("msb_out", bus_l.out, 16'h0002);
`endif

        // Hold with no command
        bus_l.shiftEn = 1'b0;
        bus_l.in      = 16'hFFFF;
        step(2);
`ifdef SHIFT_REG_ROTATE_EN
        check_eq("hold", bus_l.out, 16'h0003);
`else
        check_eq("hold", bus_l.out, 16'h0002);
`endif

        // Reset mid-shift, with load also asserted
        bus_l.ld      = 1'b1;
        bus_l.in      = 16'h5A5A;
        bus_l.shiftEn = 1'b1;
        rst           = 1'b1;
        step(1);
        check_eq("reset_mid_shift", bus_l.out, 16'h0000);
        rst      = 1'b0;
        bus_l.ld = 1'b0;
        step(1);
        check_eq("shift_from_zero", bus_l.out, 16'h0000);
        bus_l.shiftEn = 1'b0;

        // Right shift with FILL=1
        bus_r.ld = 1'b1;
        bus_r.in = 16'h0001;
        step(1);
        check_eq("r_load", bus_r.out, 16'h0001);
        bus_r.ld      = 1'b0;
        bus_r.shiftEn = 1'b1;
        step(1);
        check_eq("r_shift1", bus_r.out, 16'h8000);
        step(1);
`ifdef SHIFT_REG_ROTATE_EN
        check_eq("r_shift2", bus_r.out, 16'h4000);
`else
        check_eq("r_shift2", bus_r.out, 16'hC000);
        step(14);
        check_eq("r_fill_all", bus_r.out, 16'hFFFF);
`endif
        bus_r.shiftEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
